// File: rtl/quadrature_step_controller.sv
// quadrature_step_controller: runs counted quadrature moves at a programmed step period
// and tracks a signed position; commands arrive over a valid/ready handshake.
module quadrature_step_controller #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 16,
    parameter int POS_W = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic             abort,
    output logic             phs_0,
    output logic             phs_90,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] pos
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [1:0]       p_q, p_d;
    logic [1:0]       phs_q, phs_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d, done_q, done_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            p_q     <= '0;
            phs_q   <= '0;
            pos_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            phs_q   <= phs_d;
            pos_q   <= pos_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        pos_d   = pos_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (cmd_valid) begin
                dir_d = cmd_dir;
                div_d = cmd_div;
                rem_d = cmd_steps;
                cnt_d = cmd_div;
                if (cmd_steps == '0) done_d = 1'b1;
                else state_d = RUN;
            end
        end else if (abort) begin
            state_d = IDLE;
        end else if (cnt_q == '0) begin
            p_d   = dir_q ? p_q + 2'd1 : p_q - 2'd1;
            pos_d = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
            rem_d = rem_q - CNT_W'(1);
            cnt_d = div_q;
            if (rem_q == CNT_W'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
        // Gray mapping of the phase index keeps exactly one output toggling per step.
        phs_d = {p_d[1] ^ p_d[0], p_d[1]};
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign phs_0     = phs_q[1];
    assign phs_90    = phs_q[0];
    assign pos       = pos_q;
endmodule
